vertex_cl_packer: RTL and testbench

Write-back counterpart of the vertex RAM: it reads a contiguous range of vertices out of the on-chip vertex RAM one per cycle and reassembles them into 512-bit cachelines for the memory write path. It uses the same cacheline layout the RAM's cacheline loader expects: 8 vertices per line, slot i at bits [i*32+31 : i*32], bits [511:256] zero. It sits between the vertex RAM read port and the cacheline write requester at the end of an SSSP iteration.

---
 rtl/graph_pkg.sv | 21 ++
 rtl/vertex_cl_assembler.sv | 78 +++++++
 rtl/vertex_cl_packer.sv | 147 ++++++++++++++
 tb/tb_vertex_cl_packer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// Shared vertex and cacheline definitions for the vertex RAM write-back path.
// A cacheline carries eight 32-bit vertices in its low half; the high half is always zero.
package graph_pkg;

   typedef logic [31:0] vertex_t;

   localparam int CL_W        = 512;
   localparam int SLOT_W      = 32;
   localparam int VERT_PER_CL = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } packer_state_t;

   function automatic logic [CL_W-1:0] to_cacheline(input vertex_t [VERT_PER_CL-1:0] slots);
      return {{(CL_W - VERT_PER_CL*SLOT_W){1'b0}}, slots};
   endfunction

endpackage

// File: rtl/vertex_cl_assembler.sv
// Slot-tagged assembly register feeding a valid/ready output register.
// A completed line waits in the assembly register while the output register is still occupied.
module vertex_cl_assembler
   import graph_pkg::*;
#(
   parameter int ADDR_W = 8
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              commit_inc,
   input  logic              ret_valid,
   input  logic [ADDR_W-1:0] ret_addr,
   input  vertex_t           ret_data,
   input  logic              cl_ready,
   output logic [CL_W-1:0]   cl_out,
   output logic [ADDR_W-4:0] cl_idx,
   output logic              cl_valid,
   output logic [1:0]        committed,
   output logic              xfer
);

   vertex_t [VERT_PER_CL-1:0] asm_slots;
   vertex_t [VERT_PER_CL-1:0] asm_merged;
   logic [ADDR_W-4:0]         asm_idx;
   logic                      asm_full;
   logic [2:0]                ret_slot;
   logic [ADDR_W-4:0]         ret_line;
   logic                      landing_last;
   logic                      move;

   // The merged view lets slot 7 go straight to the output register in the cycle it lands.
   always_comb begin
      ret_slot   = ret_addr[2:0];
      ret_line   = ret_addr[ADDR_W-1:3];
      asm_merged = asm_slots;
      if (ret_valid) begin
         asm_merged[ret_slot] = ret_data;
      end
      landing_last = ret_valid && (ret_slot == 3'd7);
      xfer         = cl_valid && cl_ready;
      move         = (asm_full || landing_last) && (!cl_valid || cl_ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         asm_slots <= '0;
         asm_idx   <= '0;
         asm_full  <= 1'b0;
         cl_out    <= '0;
         cl_idx    <= '0;
         cl_valid  <= 1'b0;
         committed <= 2'd0;
      end else begin
         if (ret_valid) begin
            asm_slots <= asm_merged;
            asm_idx   <= ret_line;
         end

         if (move) begin
            asm_full <= 1'b0;
         end else if (landing_last) begin
            asm_full <= 1'b1;
         end

         if (move) begin
            cl_out   <= to_cacheline(asm_merged);
            cl_idx   <= landing_last ? ret_line : asm_idx;
            cl_valid <= 1'b1;
         end else if (xfer) begin
            cl_valid <= 1'b0;
         end

         committed <= committed + 2'(commit_inc) - 2'(xfer);
      end
   end

endmodule

// File: rtl/vertex_cl_packer.sv
// Reads a line-aligned vertex range from the vertex RAM one per cycle and emits 512-bit cachelines.
// Holds the FSM, line/slot counters and the read-return tag pipeline; packing lives in the assembler.
module vertex_cl_packer
   import graph_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 2
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-3:0] num_cl,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] r_addr,
   input  vertex_t           vertex_in,
   output logic [CL_W-1:0]   cl_out,
   output logic [ADDR_W-4:0] cl_idx,
   output logic              cl_valid,
   input  logic              cl_ready
);

   localparam int LINE_W = ADDR_W - 3;

   packer_state_t     state;
   packer_state_t     state_next;
   logic [LINE_W-1:0] line_addr;
   logic [2:0]        slot;
   logic [ADDR_W-3:0] lines_left;
   logic              zero_pend;
   logic              iss_valid;
   logic              tag_valid [RD_LAT];
   logic [ADDR_W-1:0] tag_addr  [RD_LAT];

   logic              start_ok;
   logic              issue_now;
   logic [LINE_W-1:0] issue_line;
   logic [2:0]        issue_slot;
   logic              commit_inc;
   logic              last_xfer;
   logic [1:0]        committed;
   logic              xfer;
   logic              unused_low_bits;

   assign unused_low_bits = ^base_addr[2:0];
   assign start_ok        = (state == S_IDLE) && start && !zero_pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start_ok && (num_cl != '0)) state_next = S_ISSUE;
         S_ISSUE: if (issue_now && (slot == 3'd7) && (lines_left == 1)) state_next = S_WAIT;
         S_WAIT:  if (last_xfer) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Slot 0 of a line is admitted only while fewer than two lines are committed;
   // the first read is issued straight from IDLE so r_addr is valid the cycle after start.
   always_comb begin
      issue_now  = 1'b0;
      issue_line = line_addr;
      issue_slot = slot;
      last_xfer  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_ok && (num_cl != '0)) begin
               issue_now  = 1'b1;
               issue_line = base_addr[ADDR_W-1:3];
               issue_slot = 3'd0;
            end
         end
         S_ISSUE: issue_now = (slot != 3'd0) || (committed < 2'd2);
         S_WAIT:  last_xfer = xfer && (committed == 2'd1);
         default: issue_now = 1'b0;
      endcase
      commit_inc = issue_now && (issue_slot == 3'd0);
      busy       = (state != S_IDLE) || zero_pend;
      done       = last_xfer || zero_pend;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr     <= '0;
         iss_valid  <= 1'b0;
         line_addr  <= '0;
         slot       <= 3'd0;
         lines_left <= '0;
         zero_pend  <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_valid[i] <= 1'b0;
            tag_addr[i]  <= '0;
         end
      end else begin
         zero_pend <= start_ok && (num_cl == '0);
         iss_valid <= issue_now;

         if (issue_now) begin
            r_addr    <= {issue_line, issue_slot};
            slot      <= issue_slot + 3'd1;
            line_addr <= (issue_slot == 3'd7) ? issue_line + LINE_W'(1) : issue_line;
         end

         if (start_ok && (num_cl != '0)) begin
            lines_left <= num_cl;
         end else if (issue_now && (issue_slot == 3'd7)) begin
            lines_left <= lines_left - 1'b1;
         end

         // The last stage lines up with vertex_in for the address issued RD_LAT cycles earlier.
         tag_valid[0] <= iss_valid;
         tag_addr[0]  <= r_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_addr[i]  <= tag_addr[i-1];
         end
      end
   end

   vertex_cl_assembler #(
      .ADDR_W(ADDR_W)
   ) u_assembler (
      .clk        (clk),
      .reset      (reset),
      .commit_inc (commit_inc),
      .ret_valid  (tag_valid[RD_LAT-1]),
      .ret_addr   (tag_addr[RD_LAT-1]),
      .ret_data   (vertex_in),
      .cl_ready   (cl_ready),
      .cl_out     (cl_out),
      .cl_idx     (cl_idx),
      .cl_valid   (cl_valid),
      .committed  (committed),
      .xfer       (xfer)
   );

endmodule

// File: tb/tb_vertex_cl_packer.sv
// Directed and randomized bench for vertex_cl_packer against a RAM model and a queue of expected lines.
module tb_vertex_cl_packer;
   import graph_pkg::*;

   localparam int ADDR_W = 8;
   localparam int RD_LAT = 2;

   typedef struct {
      logic [4:0]   idx;
      logic [511:0] data;
   } line_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        base_addr;
   logic [5:0]        num_cl;
   logic              busy;
   logic              done;
   logic [7:0]        r_addr;
   vertex_t           vertex_in = '0;
   logic [511:0]      cl_out;
   logic [4:0]        cl_idx;
   logic              cl_valid;
   logic              cl_ready;

   vertex_t ram [256];
   vertex_t ram_q1 = '0;
   line_t   exp_q [$];
   int      tests = 0;
   int      failures = 0;

   vertex_cl_packer #(
      .ADDR_W(ADDR_W),
      .RD_LAT(RD_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_cl    (num_cl),
      .busy      (busy),
      .done      (done),
      .r_addr    (r_addr),
      .vertex_in (vertex_in),
      .cl_out    (cl_out),
      .cl_idx    (cl_idx),
      .cl_valid  (cl_valid),
      .cl_ready  (cl_ready)
   );

   always #5 clk = ~clk;

   // Two-stage RAM: bank register then output register.
   always @(posedge clk) begin
      ram_q1    <= ram[r_addr];
      vertex_in <= ram_q1;
   end

   task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_expected(input logic [7:0] base, input int n);
      exp_q.delete();
      for (int l = 0; l < n; l++) begin
         line_t ln;
         ln.idx  = 5'((int'(base) / 8 + l) % 32);
         ln.data = '0;
         for (int s = 0; s < 8; s++) begin
            ln.data[s*32 +: 32] = ram[int'(ln.idx) * 8 + s];
         end
         exp_q.push_back(ln);
      end
   endtask

   // Runs one job from a start strobe; cyc 0 is the strobe cycle, outputs sampled 1 time unit after negedge.
   task automatic apply_stimulus(input logic [7:0] base, input int n, input int stall,
                                 input bit rand_ready, input bit spacing, input bit poke);
      bit           finished = 0;
      bit           held = 0;
      logic [511:0] held_data = '0;
      logic [4:0]   held_idx = '0;
      int           first_valid = -1;
      int           last_xfer = -1;
      int           budget = 60 + n * 48 + stall;
      build_expected(base, n);
      base_addr = base;
      num_cl    = 6'(n);
      for (int cyc = 0; cyc < budget; cyc++) begin
         bit xfer;
         bit exp_done;
         start    = (cyc == 0) || (poke && cyc == 5);
         if (poke && cyc == 5) begin
            base_addr = 8'($urandom);
            num_cl    = 6'($urandom_range(1, 8));
         end
         cl_ready = (cyc < stall) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         #1;
         xfer     = cl_valid && cl_ready;
         exp_done = 0;
         if (held) begin
            check_output("hold_valid", cl_valid, 1'b1);
            check_output("hold_data", cl_out, held_data);
            check_output("hold_idx", cl_idx, held_idx);
         end
         held      = cl_valid && !cl_ready;
         held_data = cl_out;
         held_idx  = cl_idx;
         if (cyc == 1) check_output("busy_after_start", busy, 1'b1);
         if (cyc == 1 && n > 0) check_output("first_raddr", r_addr, {base[7:3], 3'b000});
         if (spacing && cyc >= 1 && cyc <= 8 * n) begin
            logic [4:0] ln = base[7:3] + 5'((cyc - 1) / 8);
            check_output("raddr_stream", r_addr, {ln, 3'((cyc - 1) % 8)});
         end
         if (stall >= 26 && cyc == 25) begin
            logic [4:0] ln2 = base[7:3] + 5'd1;
            check_output("stalled_raddr", r_addr, {ln2, 3'd7});
         end
         if (cl_valid && first_valid < 0) begin
            first_valid = cyc;
            // Slot-0 address at cycle 1, then 8 reads plus RD_LAT to fill the line.
            check_output("first_valid_cycle", cyc, 1 + 8 + RD_LAT);
         end
         if (xfer) begin
            if (exp_q.size() == 0) begin
               check_output("extra_line", cl_valid, 1'b0);
            end else begin
               line_t e = exp_q.pop_front();
               check_output("line_data", cl_out, e.data);
               check_output("line_idx", cl_idx, e.idx);
               if (spacing && last_xfer >= 0) check_output("line_spacing", cyc - last_xfer, 8);
               last_xfer = cyc;
               exp_done  = (exp_q.size() == 0);
            end
         end
         if (n == 0) begin
            exp_done = (cyc == 1);
            check_output("zero_no_valid", cl_valid, 1'b0);
         end
         if (done || exp_done) check_output("done", done, exp_done);
         if (done) finished = 1;
         @(negedge clk);
         start = 1'b0;
         if (finished && (n > 0 || cyc >= 12)) break;
      end
      check_output("job_finished", finished, 1'b1);
      check_output("lines_drained", exp_q.size(), 0);
      #1;
      check_output("idle_after_done", busy, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      cl_ready  = 1'b0;
      base_addr = '0;
      num_cl    = '0;
      for (int v = 0; v < 256; v++) ram[v] = 32'(v);
      repeat (2) @(negedge clk);
      #1;
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_done", done, 1'b0);
      check_output("rst_valid", cl_valid, 1'b0);
      check_output("rst_cl_out", cl_out, '0);
      check_output("rst_cl_idx", cl_idx, 5'd0);
      check_output("rst_raddr", r_addr, 8'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] single line, identity RAM");
      apply_stimulus(8'h10, 1, 0, 0, 0, 0);
      $display("[TB] four lines back to back");
      apply_stimulus(8'h10, 4, 0, 0, 1, 0);
      $display("[TB] three lines under 30 cycles of backpressure");
      apply_stimulus(8'h20, 3, 30, 0, 0, 0);
      $display("[TB] line address wrap");
      apply_stimulus(8'hF8, 2, 0, 0, 1, 0);
      $display("[TB] zero-line job");
      apply_stimulus(8'h30, 0, 0, 0, 0, 0);

      $display("[TB] reset mid-line");
      base_addr = 8'h40;
      num_cl    = 6'd2;
      start     = 1'b1;
      cl_ready  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_output("midrst_busy", busy, 1'b0);
      check_output("midrst_done", done, 1'b0);
      check_output("midrst_valid", cl_valid, 1'b0);
      check_output("midrst_cl_out", cl_out, '0);
      check_output("midrst_cl_idx", cl_idx, 5'd0);
      check_output("midrst_raddr", r_addr, 8'd0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         check_output("post_reset_quiet", {cl_valid, done, busy}, 3'b000);
      end
      @(negedge clk);
      apply_stimulus(8'h48, 1, 0, 0, 0, 0);

      $display("[TB] randomized jobs");
      for (int v = 0; v < 256; v++) ram[v] = $urandom;
      for (int j = 0; j < 6; j++) begin
         apply_stimulus(8'($urandom), $urandom_range(1, 5), $urandom_range(0, 12), 1, 0, 1);
      end
      apply_stimulus(8'($urandom), 32, 0, 0, 1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
